// File: rtl/nbit_seq_divider.sv
// nbit_seq_divider: multi-cycle unsigned restoring divider behind a
// start/done handshake. One trial subtraction per clock through an n+1 bit
// add/subtract datapath. A zero divisor is flagged in a single cycle.

// n-bit add/subtract datapath: sum = a + b when sub=0, a - b when sub=1
// (subtrahend inverted, carry-in 1).
module nbit_addsub #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = a + (b ^ {W{sub}}) + {{(W - 1){1'b0}}, sub};

endmodule

module nbit_seq_divider #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next_state;

    // The partial remainder is kept in n bits because it is always below the
    // divisor between iterations. Only the shifted value needs n+1 bits.
    logic [n-1:0]  divisor_q;
    logic [n-1:0]  q_reg;
    logic [n-1:0]  r_reg;
    logic [CW-1:0] count;

    logic [n:0]    shift_r;
    logic [n:0]    trial;
    logic [n-1:0]  next_r;
    logic [n-1:0]  next_q;
    logic          last_iter;
    logic          accept;
    logic          zero_div;

    assign shift_r   = {r_reg, q_reg[n-1]};
    assign last_iter = (count == CW'(n - 1));
    assign accept    = (state == IDLE) && start;
    assign zero_div  = (divisor == '0);

    // Trial subtraction r - {0, divisor} through the add/subtract datapath.
    nbit_addsub #(
        .W(n + 1)
    ) u_trial_sub (
        .a  (shift_r),
        .b  ({1'b0, divisor_q}),
        .sub(1'b1),
        .sum(trial)
    );

    // Restore on borrow (trial MSB set), otherwise keep the difference.
    always_comb begin
        next_r = trial[n-1:0];
        next_q = {q_reg[n-2:0], 1'b1};
        if (trial[n]) begin
            next_r = shift_r[n-1:0];
            next_q = {q_reg[n-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: load operands on an accepted start, iterate in RUN, and
    // publish results only on the transition into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q   <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                divisor_q   <= divisor;
                q_reg       <= dividend;
                r_reg       <= '0;
                count       <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            r_reg <= next_r;
            q_reg <= next_q;
            count <= count + 1'b1;
            if (last_iter) begin
                quotient  <= next_q;
                remainder <= next_r;
            end
        end
    end

endmodule

// File: tb/tb_nbit_seq_divider.sv
// tb_nbit_seq_divider: directed checks of the sequential divider with
// hand-computed results, plus a short random sweep against a reference model.

module tb_nbit_seq_divider;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int fails  = 0;

    nbit_seq_divider #(
        .n(N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until done is seen; reports edges elapsed and busy cycles.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 60) begin
            if (busy) busy_cycles++;
            next_cycle();
            edges++;
        end
    endtask

    // One complete division from IDLE, checking latency, results and handshake.
    task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic edbz, input int elat);
        int edges;
        int bc;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        next_cycle();
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        wait_done(edges, bc);
        check({tag, " latency"}, edges, elat);
        check({tag, " busy_cycles"}, bc, elat);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, edbz);
        check({tag, " ready_in_done"}, ready, 1'b0);
        next_cycle();
        check({tag, " done_one_cycle"}, done, 1'b0);
        check({tag, " ready_after"}, ready, 1'b1);
    endtask

    initial begin
        int edges;
        int bc;
        int pre;
        bit seen_done;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [31:0]  prod;

        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2 rst_n = 1'b0;
        repeat (3) next_cycle();
        check("reset ready", ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 16'h0);
        check("reset remainder", remainder, 16'h0);
        check("reset dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        next_cycle();

        run_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        run_div("FFFF/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
        run_div("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 16);
        run_div("8000/FFFF", 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 16);
        run_div("1234/0", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 0);
        run_div("200/10", 16'd200, 16'd10, 16'd20, 16'd0, 1'b0, 16);

        // Second start while busy must be ignored.
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        next_cycle();
        start    = 1'b0;
        repeat (4) next_cycle();
        dividend = 16'd9;
        divisor  = 16'd3;
        start    = 1'b1;
        next_cycle();
        start    = 1'b0;
        pre      = 5;
        wait_done(edges, bc);
        check("ignore latency", pre + edges, 16);
        check("ignore quotient", quotient, 16'd333);
        check("ignore remainder", remainder, 16'd1);
        next_cycle();
        check("ignore ready_after", ready, 1'b1);

        // Reset in the middle of a running division.
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        next_cycle();
        start    = 1'b0;
        repeat (7) next_cycle();
        check("midrun busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrun ready", ready, 1'b1);
        check("midrun busy", busy, 1'b0);
        check("midrun quotient", quotient, 16'd0);
        check("midrun remainder", remainder, 16'd0);
        check("midrun dbz", div_by_zero, 1'b0);
        seen_done = 1'b0;
        repeat (3) begin
            next_cycle();
            if (done) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            next_cycle();
            if (done) seen_done = 1'b1;
        end
        check("midrun no_done", seen_done, 1'b0);
        run_div("50/7", 16'd50, 16'd7, 16'd7, 16'd1, 1'b0, 16);

        // Back-to-back with start held high.
        dividend = 16'd60000;
        divisor  = 16'd7;
        start    = 1'b1;
        next_cycle();
        wait_done(edges, bc);
        check("b2b0 latency", edges, 16);
        check("b2b0 quotient", quotient, 16'd8571);
        check("b2b0 remainder", remainder, 16'd3);
        dividend = 16'd1000;
        divisor  = 16'd33;
        next_cycle();
        wait_done(edges, bc);
        check("b2b1 spacing", edges + 1, 18);
        check("b2b1 quotient", quotient, 16'd30);
        check("b2b1 remainder", remainder, 16'd10);
        dividend = 16'hFFFF;
        divisor  = 16'hFFFF;
        next_cycle();
        wait_done(edges, bc);
        check("b2b2 spacing", edges + 1, 18);
        check("b2b2 quotient", quotient, 16'd1);
        check("b2b2 remainder", remainder, 16'd0);
        start = 1'b0;
        next_cycle();
        check("b2b ready_after", ready, 1'b1);

        // Random sweep against the reference model and the invariant.
        for (int i = 0; i < 300; i++) begin
            ra = N'($urandom);
            rb = (i % 2 == 0) ? N'($urandom_range(1, 300)) : N'($urandom_range(1, 65535));
            run_div("rand", ra, rb, ra / rb, ra % rb, 1'b0, 16);
            prod = 32'(quotient) * 32'(rb) + 32'(remainder);
            check("rand invariant", prod, 32'(ra));
            check("rand rem_lt_div", remainder < rb, 1'b1);
        end

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
